// File: rtl/pp_pipeline_accel_flow_control_loop_pipe_ctrl_pkg.sv
// pp_pipeline_accel_flow_ctrl_pkg: shared FSM states and helper functions for the loop pipe controller
package pp_pipeline_accel_flow_ctrl_pkg;
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_HOLD = 2'd2} state_e;
  function automatic int init_cnt_w(input int iters);
    return $clog2(iters + 1);
  endfunction
  function automatic logic calc_iter_last(input logic [31:0] idx, input logic [31:0] tc);
    return (tc != 32'd0) && (idx == tc - 32'd1);
  endfunction
endpackage

// File: rtl/pp_pipeline_accel_flow_control_loop_pipe_ctrl_if.sv
// pp_pipeline_accel_flow_control_loop_pipe_ctrl_if: outer block handshake plus loop-body handshake bundle
interface pp_pipeline_accel_flow_control_loop_pipe_ctrl_if #(parameter int CNT_W = 16) ();
  logic             ap_start;
  logic             ap_continue;
  logic             ap_ready;
  logic             ap_done;
  logic             ap_idle;
  logic             ap_start_int;
  logic             ap_ready_int;
  logic             ap_done_int;
  logic             ap_continue_int;
  logic             ap_loop_init;
  logic             ap_loop_exit_ready;
  logic             ap_loop_exit_done;
  logic [CNT_W-1:0] trip_count;
  logic [CNT_W-1:0] iter_idx;
  logic             iter_last;
  logic             iter_ovf;
  modport master (
    input  ap_start, ap_continue, ap_ready_int, ap_done_int, ap_loop_exit_ready, ap_loop_exit_done, trip_count,
    output ap_ready, ap_done, ap_idle, ap_start_int, ap_continue_int, ap_loop_init, iter_idx, iter_last, iter_ovf
  );
  modport slave (
    output ap_start, ap_continue, ap_ready_int, ap_done_int, ap_loop_exit_ready, ap_loop_exit_done, trip_count,
    input  ap_ready, ap_done, ap_idle, ap_start_int, ap_continue_int, ap_loop_init, iter_idx, iter_last, iter_ovf
  );
endinterface

// File: rtl/pp_pipeline_accel_flow_control_loop_pipe_ctrl_iter_cnt.sv
// pp_pipeline_accel_flow_ctrl_iter_cnt: per-run iteration index with last-iteration and sticky wrap flags
module pp_pipeline_accel_flow_ctrl_iter_cnt
  import pp_pipeline_accel_flow_ctrl_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ready_i,
  input  logic             clear_i,
  input  logic             run_start_i,
  input  logic [CNT_W-1:0] trip_count_i,
  output logic [CNT_W-1:0] iter_idx_o,
  output logic             iter_last_o,
  output logic             iter_ovf_o
);
  logic [CNT_W-1:0] idx_q, idx_d;
  logic             ovf_q, ovf_d;
  always_comb begin
    idx_d = clear_i ? '0 : ready_i ? idx_q + CNT_W'(1) : idx_q;
    ovf_d = (~clear_i & ready_i & (&idx_q)) ? 1'b1 : run_start_i ? 1'b0 : ovf_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      idx_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      idx_q <= idx_d;
      ovf_q <= ovf_d;
    end
  end
  assign iter_idx_o  = idx_q;
  assign iter_ovf_o  = ovf_q;
  assign iter_last_o = calc_iter_last(32'(idx_q), 32'(trip_count_i));
endmodule

// File: rtl/pp_pipeline_accel_flow_control_loop_pipe_ctrl.sv
// pp_pipeline_accel_flow_control_loop_pipe_ctrl: block-level start/done flow control around a pipelined loop body
module pp_pipeline_accel_flow_control_loop_pipe_ctrl
  import pp_pipeline_accel_flow_ctrl_pkg::*;
#(
  parameter int INIT_ITERS   = 1,
  parameter int HAS_CONTINUE = 0,
  parameter int CNT_W        = 16
) (
  input logic ap_clk,
  input logic ap_rst,
  pp_pipeline_accel_flow_control_loop_pipe_ctrl_if.master bus
);
  localparam int INIT_CNT_W = init_cnt_w(INIT_ITERS);
  localparam logic [INIT_CNT_W-1:0] INIT_LAST = INIT_CNT_W'(INIT_ITERS - 1);
  localparam bit HC = (HAS_CONTINUE != 0);
  state_e                state_q;
  logic                  init_act_q, init_act_d;
  logic [INIT_CNT_W-1:0] init_cnt_q, init_cnt_d;
  logic                  done_pending_q, done_pending_d;
  logic                  start_int;
  logic                  run_start;
  assign start_int = bus.ap_start & (~HC | ~done_pending_q);
  assign run_start = (state_q == S_IDLE) & start_int;
  always_comb begin
    init_act_d     = bus.ap_loop_exit_done | (init_act_q & ~(bus.ap_ready_int & (init_cnt_q == INIT_LAST)));
    init_cnt_d     = bus.ap_loop_exit_done ? '0 :
                     (bus.ap_ready_int & init_act_q) ? init_cnt_q + INIT_CNT_W'(1) : init_cnt_q;
    done_pending_d = HC ? (bus.ap_continue ? 1'b0 : bus.ap_done_int ? 1'b1 : done_pending_q)
                        : (bus.ap_done_int ? 1'b1 : start_int ? 1'b0 : done_pending_q);
  end
  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      state_q        <= S_IDLE;
      init_act_q     <= 1'b1;
      init_cnt_q     <= '0;
      done_pending_q <= 1'b0;
    end else begin
      init_act_q     <= init_act_d;
      init_cnt_q     <= init_cnt_d;
      done_pending_q <= done_pending_d;
      case (state_q)
        S_IDLE:  state_q <= start_int ? S_RUN : S_IDLE;
        S_RUN:   state_q <= (HC ? (bus.ap_done_int & bus.ap_continue) : bus.ap_loop_exit_done) ? S_IDLE :
                            bus.ap_loop_exit_done ? S_HOLD : S_RUN;
        S_HOLD:  state_q <= bus.ap_continue ? S_IDLE : S_HOLD;
        default: state_q <= S_IDLE;
      endcase
    end
  end
  assign bus.ap_start_int    = start_int;
  assign bus.ap_ready        = bus.ap_loop_exit_ready;
  assign bus.ap_done         = bus.ap_done_int | (done_pending_q & (HC | ~start_int));
  assign bus.ap_continue_int = ~HC | ~done_pending_q | bus.ap_continue;
  assign bus.ap_idle         = (state_q == S_IDLE) & ~done_pending_q;
  assign bus.ap_loop_init    = init_act_q & bus.ap_start;
  pp_pipeline_accel_flow_ctrl_iter_cnt #(.CNT_W(CNT_W)) u_iter_cnt (
    .clk          (ap_clk),
    .rst          (ap_rst),
    .ready_i      (bus.ap_ready_int),
    .clear_i      (bus.ap_loop_exit_done),
    .run_start_i  (run_start),
    .trip_count_i (bus.trip_count),
    .iter_idx_o   (bus.iter_idx),
    .iter_last_o  (bus.iter_last),
    .iter_ovf_o   (bus.iter_ovf)
  );
endmodule

// File: tb/tb_pp_pipeline_accel_flow_control_loop_pipe_ctrl.sv
// tb_pp_pipeline_accel_flow_control_loop_pipe_ctrl: directed checks over four parameter configurations
module tb_pp_pipeline_accel_flow_control_loop_pipe_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_chk = 0;
  int   n_fail = 0;
  always #5 clk = ~clk;
  pp_pipeline_accel_flow_control_loop_pipe_ctrl_if #(.CNT_W(16)) if0 ();
  pp_pipeline_accel_flow_control_loop_pipe_ctrl_if #(.CNT_W(16)) if1 ();
  pp_pipeline_accel_flow_control_loop_pipe_ctrl_if #(.CNT_W(16)) if2 ();
  pp_pipeline_accel_flow_control_loop_pipe_ctrl_if #(.CNT_W(4))  if3 ();
  pp_pipeline_accel_flow_control_loop_pipe_ctrl #(.INIT_ITERS(1), .HAS_CONTINUE(0), .CNT_W(16))
    d0 (.ap_clk(clk), .ap_rst(rst), .bus(if0));
  pp_pipeline_accel_flow_control_loop_pipe_ctrl #(.INIT_ITERS(3), .HAS_CONTINUE(0), .CNT_W(16))
    d1 (.ap_clk(clk), .ap_rst(rst), .bus(if1));
  pp_pipeline_accel_flow_control_loop_pipe_ctrl #(.INIT_ITERS(1), .HAS_CONTINUE(1), .CNT_W(16))
    d2 (.ap_clk(clk), .ap_rst(rst), .bus(if2));
  pp_pipeline_accel_flow_control_loop_pipe_ctrl #(.INIT_ITERS(1), .HAS_CONTINUE(0), .CNT_W(4))
    d3 (.ap_clk(clk), .ap_rst(rst), .bus(if3));
  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  initial begin
    {if0.ap_start, if0.ap_continue, if0.ap_ready_int, if0.ap_done_int, if0.ap_loop_exit_ready, if0.ap_loop_exit_done} = '0;
    {if1.ap_start, if1.ap_continue, if1.ap_ready_int, if1.ap_done_int, if1.ap_loop_exit_ready, if1.ap_loop_exit_done} = '0;
    {if2.ap_start, if2.ap_continue, if2.ap_ready_int, if2.ap_done_int, if2.ap_loop_exit_ready, if2.ap_loop_exit_done} = '0;
    {if3.ap_start, if3.ap_continue, if3.ap_ready_int, if3.ap_done_int, if3.ap_loop_exit_ready, if3.ap_loop_exit_done} = '0;
    if0.trip_count = '0;
    if1.trip_count = '0;
    if2.trip_count = '0;
    if3.trip_count = 4'd5;
    step();
    step();
    rst = 1'b0;
    #1;
    check("rst_done", if0.ap_done, 0);
    check("rst_idle", if0.ap_idle, 1);
    check("rst_init", if0.ap_loop_init, 0);
    check("rst_idx", if0.iter_idx, 0);
    check("rst_ovf", if0.iter_ovf, 0);
    if0.ap_loop_exit_ready = 1'b1;
    #1;
    check("ready_pass", if0.ap_ready, 1);
    if0.ap_loop_exit_ready = 1'b0;
    // run with INIT_ITERS=1, done cached until the next start
    if0.ap_start = 1'b1;
    #1;
    check("t1_init0", if0.ap_loop_init, 1);
    check("t1_start_int", if0.ap_start_int, 1);
    check("t1_cont_int", if0.ap_continue_int, 1);
    step();
    for (int i = 0; i < 3; i++) begin
      if0.ap_ready_int = 1'b1;
      #1;
      check($sformatf("t1_init_p%0d", i), if0.ap_loop_init, (i == 0) ? 1 : 0);
      step();
      if0.ap_ready_int = 1'b0;
    end
    #1;
    check("t1_idx3", if0.iter_idx, 3);
    check("t1_last_tc0", if0.iter_last, 0);
    if0.ap_start = 1'b0;
    if0.ap_loop_exit_done = 1'b1;
    if0.ap_done_int = 1'b1;
    #1;
    check("t1_done_pulse", if0.ap_done, 1);
    step();
    if0.ap_loop_exit_done = 1'b0;
    if0.ap_done_int = 1'b0;
    #1;
    check("t1_done_held", if0.ap_done, 1);
    check("t1_idle_pend", if0.ap_idle, 0);
    check("t1_idx_clr", if0.iter_idx, 0);
    step();
    check("t1_done_held2", if0.ap_done, 1);
    if0.ap_start = 1'b1;
    #1;
    check("t1_done_drop", if0.ap_done, 0);
    check("t1_init_back", if0.ap_loop_init, 1);
    step();
    check("t1_done_after", if0.ap_done, 0);
    check("t1_run_idle", if0.ap_idle, 0);
    if0.ap_start = 1'b0;
    // three-iteration init window
    if1.ap_start = 1'b1;
    step();
    for (int i = 0; i < 5; i++) begin
      if1.ap_ready_int = 1'b1;
      #1;
      check($sformatf("t2_init_p%0d", i), if1.ap_loop_init, (i < 3) ? 1 : 0);
      step();
      if1.ap_ready_int = 1'b0;
    end
    if1.ap_loop_exit_done = 1'b1;
    if1.ap_ready_int = 1'b1;
    step();
    if1.ap_loop_exit_done = 1'b0;
    if1.ap_ready_int = 1'b0;
    #1;
    check("t2_init_reload", if1.ap_loop_init, 1);
    check("t2_idx_clr", if1.iter_idx, 0);
    if1.ap_start = 1'b0;
    // done held until ap_continue
    if2.ap_start = 1'b1;
    #1;
    check("t3_start_int", if2.ap_start_int, 1);
    step();
    if2.ap_loop_exit_done = 1'b1;
    if2.ap_done_int = 1'b1;
    #1;
    check("t3_done_pulse", if2.ap_done, 1);
    step();
    if2.ap_loop_exit_done = 1'b0;
    if2.ap_done_int = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      check($sformatf("t3_done_c%0d", i), if2.ap_done, 1);
      check($sformatf("t3_gate_c%0d", i), if2.ap_start_int, 0);
      check($sformatf("t3_cont_c%0d", i), if2.ap_continue_int, 0);
      check($sformatf("t3_idle_c%0d", i), if2.ap_idle, 0);
      step();
    end
    if2.ap_continue = 1'b1;
    #1;
    check("t3_cont_pass", if2.ap_continue_int, 1);
    step();
    if2.ap_continue = 1'b0;
    if2.ap_start = 1'b0;
    #1;
    check("t3_done_ack", if2.ap_done, 0);
    check("t3_idle_ack", if2.ap_idle, 1);
    // done_int coincident with ap_continue
    if2.ap_start = 1'b1;
    #1;
    check("t4_start_int", if2.ap_start_int, 1);
    step();
    if2.ap_start = 1'b0;
    if2.ap_done_int = 1'b1;
    if2.ap_loop_exit_done = 1'b1;
    if2.ap_continue = 1'b1;
    #1;
    check("t4_done_pulse", if2.ap_done, 1);
    step();
    {if2.ap_done_int, if2.ap_loop_exit_done, if2.ap_continue} = '0;
    #1;
    check("t4_done_low", if2.ap_done, 0);
    check("t4_idle", if2.ap_idle, 1);
    // 4-bit counter wrap with trip_count=5
    if3.ap_start = 1'b1;
    step();
    if3.ap_start = 1'b0;
    for (int i = 0; i < 16; i++) begin
      check($sformatf("t5_last_i%0d", i), if3.iter_last, (i == 4) ? 1 : 0);
      if3.ap_ready_int = 1'b1;
      step();
      if3.ap_ready_int = 1'b0;
    end
    #1;
    check("t5_idx_wrap", if3.iter_idx, 0);
    check("t5_ovf_set", if3.iter_ovf, 1);
    if3.trip_count = 4'd0;
    #1;
    check("t5_last_tc0", if3.iter_last, 0);
    if3.trip_count = 4'd5;
    if3.ap_loop_exit_done = 1'b1;
    step();
    if3.ap_loop_exit_done = 1'b0;
    #1;
    check("t5_idle", if3.ap_idle, 1);
    check("t5_ovf_sticky", if3.iter_ovf, 1);
    if3.ap_start = 1'b1;
    step();
    if3.ap_start = 1'b0;
    check("t5_ovf_clr", if3.iter_ovf, 0);
    // reset while holding done
    if2.ap_start = 1'b1;
    step();
    if2.ap_start = 1'b0;
    if2.ap_loop_exit_done = 1'b1;
    if2.ap_done_int = 1'b1;
    step();
    if2.ap_loop_exit_done = 1'b0;
    if2.ap_done_int = 1'b0;
    for (int i = 0; i < 7; i++) begin
      if2.ap_ready_int = 1'b1;
      step();
      if2.ap_ready_int = 1'b0;
    end
    #1;
    check("t6_idx7", if2.iter_idx, 7);
    check("t6_hold_done", if2.ap_done, 1);
    check("t6_hold_idle", if2.ap_idle, 0);
    rst = 1'b1;
    if2.ap_start = 1'b1;
    step();
    check("t6_rst_done", if2.ap_done, 0);
    check("t6_rst_idx", if2.iter_idx, 0);
    check("t6_rst_idle", if2.ap_idle, 1);
    check("t6_rst_init", if2.ap_loop_init, 1);
    rst = 1'b0;
    if2.ap_start = 1'b0;
    step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
